// File: rtl/fifo_dual_ported.sv
// Two-port-in, two-port-out FIFO with first-word fall-through on the two oldest entries.
// Port 1 is always the older of two same-cycle pushes; port 2 needs two free slots.
module fifo_dual_ported #(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_flush,
    input  logic          push_1,
    output logic          ready_1,
    input  logic [DW-1:0] push_data_1,
    input  logic          push_2,
    output logic          ready_2,
    input  logic [DW-1:0] push_data_2,
    output logic [DW-1:0] pop_data_1,
    output logic          valid_1,
    input  logic          pop_1,
    output logic [DW-1:0] pop_data_2,
    output logic          valid_2,
    input  logic          pop_2
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] LIM_1 = CW'(DEPTH - 1);
    localparam logic [CW-1:0] LIM_2 = CW'(DEPTH - 2);
    localparam logic [CW-1:0] ONE   = CW'(1);
    localparam logic [CW-1:0] TWO   = CW'(2);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          acc_1, acc_2;
    logic          pop_one, pop_two;
    logic [1:0]    n_push, n_pop;

    assign ready_1    = (count_q <= LIM_1);
    assign ready_2    = (count_q <= LIM_2);
    assign valid_1    = (count_q >= ONE);
    assign valid_2    = (count_q >= TWO);
    assign pop_data_1 = mem_q[head_q];
    assign pop_data_2 = mem_q[head_q + AW'(1)];

    always_comb begin
        acc_1   = push_1 & ready_1;
        acc_2   = push_2 & ready_2;
        pop_two = pop_1 & pop_2 & valid_2;
        pop_one = pop_1 & valid_1 & ~pop_two;
        n_push  = {1'b0, acc_1} + {1'b0, acc_2};
        n_pop   = {pop_two, pop_one};

        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        // Flush drops the pointers only; stale storage stays hidden behind valid_x.
        if (valid_flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (acc_1) begin
                mem_d[tail_q] = push_data_1;
            end
            if (acc_2) begin
                mem_d[acc_1 ? tail_q + AW'(1) : tail_q] = push_data_2;
            end
            head_d  = head_q + AW'(n_pop);
            tail_d  = tail_q + AW'(n_push);
            count_d = count_q + CW'(n_push) - CW'(n_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q   <= '{default: '0};
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_fifo_dual_ported.sv
// Randomized and directed bench for fifo_dual_ported against a queue-based reference model.
module tb_fifo_dual_ported;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst, valid_flush;
    logic          push_1, push_2, pop_1, pop_2;
    logic [DW-1:0] push_data_1, push_data_2;
    logic          ready_1, ready_2, valid_1, valid_2;
    logic [DW-1:0] pop_data_1, pop_data_2;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] model_q [$];

    fifo_dual_ported #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_flush(valid_flush),
        .push_1     (push_1),
        .ready_1    (ready_1),
        .push_data_1(push_data_1),
        .push_2     (push_2),
        .ready_2    (ready_2),
        .push_data_2(push_data_2),
        .pop_data_1 (pop_data_1),
        .valid_1    (valid_1),
        .pop_1      (pop_1),
        .pop_data_2 (pop_data_2),
        .valid_2    (valid_2),
        .pop_2      (pop_2)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_model();
        int n;
        n = model_q.size();
        check_eq("ready_1", {31'b0, ready_1}, {31'b0, n <= DEPTH - 1});
        check_eq("ready_2", {31'b0, ready_2}, {31'b0, n <= DEPTH - 2});
        check_eq("valid_1", {31'b0, valid_1}, {31'b0, n >= 1});
        check_eq("valid_2", {31'b0, valid_2}, {31'b0, n >= 2});
        if (n >= 1) check_eq("pop_data_1", {16'b0, pop_data_1}, {16'b0, model_q[0]});
        if (n >= 2) check_eq("pop_data_2", {16'b0, pop_data_2}, {16'b0, model_q[1]});
    endtask

    // Called at a negedge: drives inputs, advances the model, waits one cycle, checks.
    task automatic step(input logic r, input logic fl,
                        input logic p1, input logic [DW-1:0] d1,
                        input logic p2, input logic [DW-1:0] d2,
                        input logic o1, input logic o2);
        int  n;
        bit  a1, a2;
        rst = r; valid_flush = fl;
        push_1 = p1; push_data_1 = d1;
        push_2 = p2; push_data_2 = d2;
        pop_1 = o1; pop_2 = o2;
        n = model_q.size();
        if (r || fl) begin
            model_q.delete();
        end else begin
            a1 = p1 && (n <= DEPTH - 1);
            a2 = p2 && (n <= DEPTH - 2);
            if (o1 && o2 && n >= 2) begin
                void'(model_q.pop_front());
                void'(model_q.pop_front());
            end else if (o1 && n >= 1) begin
                void'(model_q.pop_front());
            end
            if (a1) model_q.push_back(d1);
            if (a2) model_q.push_back(d2);
        end
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b1, 16'hdead, 1'b1, 16'hbeef, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 16'h1111, 1'b0, 16'h2222, 1'b0, 1'b0);
        check_eq("rst_pop_data_1", {16'b0, pop_data_1}, 32'h0);
        check_eq("rst_pop_data_2", {16'b0, pop_data_2}, 32'h0);
        check_eq("rst_ready_2", {31'b0, ready_2}, 32'h1);
    endtask

    initial begin
        rst = 1'b1; valid_flush = 1'b0;
        push_1 = 1'b0; push_2 = 1'b0; pop_1 = 1'b0; pop_2 = 1'b0;
        push_data_1 = '0; push_data_2 = '0;
        @(negedge clk);
        do_reset();

        // Dual push: port 1 older
        step(1'b0, 1'b0, 1'b1, 16'h00a0, 1'b1, 16'h00b0, 1'b0, 1'b0);
        check_eq("dual_push_d1", {16'b0, pop_data_1}, 32'h00a0);
        check_eq("dual_push_d2", {16'b0, pop_data_2}, 32'h00b0);
        // Fill to 3, port 2 dropped, port 1 fills, further push dropped
        step(1'b0, 1'b0, 1'b1, 16'h00c0, 1'b0, 16'h0, 1'b0, 1'b0);
        check_eq("three_ready_2", {31'b0, ready_2}, 32'h0);
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0bad, 1'b0, 1'b0);
        check_eq("drop2_ready_1", {31'b0, ready_1}, 32'h1);
        step(1'b0, 1'b0, 1'b1, 16'h00d0, 1'b0, 16'h0, 1'b0, 1'b0);
        check_eq("full_ready_1", {31'b0, ready_1}, 32'h0);
        step(1'b0, 1'b0, 1'b1, 16'h0bad, 1'b0, 16'h0, 1'b0, 1'b0);
        check_eq("full_drop_d2", {16'b0, pop_data_2}, 32'h00b0);
        // Flush beats push and pop
        step(1'b0, 1'b1, 1'b1, 16'h0e0e, 1'b0, 16'h0, 1'b1, 1'b0);
        check_eq("flush_valid_1", {31'b0, valid_1}, 32'h0);
        check_eq("flush_ready_2", {31'b0, ready_2}, 32'h1);

        // Double pop from three entries, then lone pop_2 ignored
        do_reset();
        step(1'b0, 1'b0, 1'b1, 16'h000a, 1'b1, 16'h000b, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'h000c, 1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1);
        check_eq("dpop_d1", {16'b0, pop_data_1}, 32'h000c);
        check_eq("dpop_valid_2", {31'b0, valid_2}, 32'h0);
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
        check_eq("pop2_alone_valid_1", {31'b0, valid_1}, 32'h1);

        // Wrap-around with steady occupancy of one
        do_reset();
        step(1'b0, 1'b0, 1'b1, 16'd0, 1'b0, 16'h0, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            check_eq("wrap_data", {16'b0, pop_data_1}, 32'(i - 1));
            if (i < 10) step(1'b0, 1'b0, 1'b1, 16'(i), 1'b0, 16'h0, 1'b1, 1'b0);
            else        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
            check_eq("wrap_valid_2", {31'b0, valid_2}, 32'h0);
        end

        // Port 2 alone into an empty FIFO
        do_reset();
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h5a5a, 1'b0, 1'b0);
        check_eq("p2_only_d1", {16'b0, pop_data_1}, 32'h5a5a);
        check_eq("p2_only_valid_2", {31'b0, valid_2}, 32'h0);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            logic r, fl;
            r  = ($urandom_range(0, 99) == 0);
            fl = ($urandom_range(0, 24) == 0);
            step(r, fl, 1'($urandom), 16'($urandom), 1'($urandom), 16'($urandom),
                 1'($urandom), 1'($urandom));
            if (r) begin
                check_eq("rnd_rst_d1", {16'b0, pop_data_1}, 32'h0);
                check_eq("rnd_rst_d2", {16'b0, pop_data_2}, 32'h0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
